// File: rtl/pipe_stage_pkg.sv
// Shared definitions for the pipeline stage register: occupancy state,
// default widths and control-field bit positions.
package pipe_stage_pkg;

  // Occupancy of the two-entry skid buffer.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } stage_state_t;

  localparam int unsigned DEF_CTRL_W = 2;
  localparam int unsigned DEF_DATA_W = 64;
  localparam int unsigned DEF_DST_W  = 5;
  localparam int unsigned DEF_CNT_W  = 32;

  // Bit positions inside the control field.
  localparam int unsigned CTRL_MEMTOREG = 1;
  localparam int unsigned CTRL_REGWRITE = 0;

endpackage

// File: rtl/pipe_stage_slot.sv
// One {ctrl, data, dst} storage entry with a load enable.
// Cleared asynchronously by the active-low reset.
module pipe_stage_slot
  import pipe_stage_pkg::*;
#(
  parameter int unsigned CTRL_W = DEF_CTRL_W,
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned DST_W  = DEF_DST_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic [CTRL_W-1:0] d_ctrl,
  input  logic [DATA_W-1:0] d_data,
  input  logic [DST_W-1:0]  d_dst,
  output logic [CTRL_W-1:0] q_ctrl,
  output logic [DATA_W-1:0] q_data,
  output logic [DST_W-1:0]  q_dst
);

  logic [CTRL_W-1:0] ctrl_q, ctrl_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [DST_W-1:0]  dst_q, dst_d;

  // Take the new entry when loaded, otherwise keep the stored one.
  always_comb begin
    ctrl_d = ctrl_q;
    data_d = data_q;
    dst_d  = dst_q;
    if (load) begin
      ctrl_d = d_ctrl;
      data_d = d_data;
      dst_d  = d_dst;
    end
  end

  // Entry storage, zeroed by reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ctrl_q <= '0;
      data_q <= '0;
      dst_q  <= '0;
    end else begin
      ctrl_q <= ctrl_d;
      data_q <= data_d;
      dst_q  <= dst_d;
    end
  end

  assign q_ctrl = ctrl_q;
  assign q_data = data_q;
  assign q_dst  = dst_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Pipeline stage register with valid/ready handshake, a two-entry skid
// buffer (main entry drives the outputs, skid entry is always younger),
// registered in_ready and a synchronous flush that produces a bubble.
// Optional stall statistics counter enabled by PIPE_STAGE_STATS_EN.
module pipe_stage_reg
  import pipe_stage_pkg::*;
#(
  parameter int unsigned CTRL_W = DEF_CTRL_W,
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned DST_W  = DEF_DST_W,
  parameter int unsigned CNT_W  = DEF_CNT_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  input  logic [DST_W-1:0]  in_dst,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [DST_W-1:0]  out_dst
`ifdef PIPE_STAGE_STATS_EN
  ,
  output logic [CNT_W-1:0]  stall_cnt
`endif
);

  stage_state_t state_q, state_d;
  logic         in_ready_q, in_ready_d;

  logic in_fire, out_fire;
  logic load_main, load_skid, main_from_skid;

  logic [CTRL_W-1:0] main_ctrl, skid_ctrl, main_ctrl_in;
  logic [DATA_W-1:0] main_data, skid_data, main_data_in;
  logic [DST_W-1:0]  main_dst, skid_dst, main_dst_in;

  assign out_valid = (state_q != ST_EMPTY);
  assign in_fire   = in_valid & in_ready_q;
  assign out_fire  = out_valid & out_ready;

  // Occupancy transitions and entry load selection; flush overrides all.
  always_comb begin
    state_d        = state_q;
    load_main      = 1'b0;
    load_skid      = 1'b0;
    main_from_skid = 1'b0;
    if (flush) begin
      state_d = ST_EMPTY;
    end else begin
      unique case (state_q)
        ST_EMPTY: begin
          if (in_fire) begin
            state_d   = ST_ONE;
            load_main = 1'b1;
          end
        end
        ST_ONE: begin
          if (in_fire && out_fire) begin
            load_main = 1'b1;
          end else if (in_fire) begin
            state_d   = ST_TWO;
            load_skid = 1'b1;
          end else if (out_fire) begin
            state_d = ST_EMPTY;
          end
        end
        ST_TWO: begin
          if (out_fire) begin
            state_d        = ST_ONE;
            load_main      = 1'b1;
            main_from_skid = 1'b1;
          end
        end
        default: state_d = ST_EMPTY;
      endcase
    end
    in_ready_d = (state_d != ST_TWO);
  end

  // Main entry refills from the skid when it drains, otherwise from upstream.
  always_comb begin
    main_ctrl_in = in_ctrl;
    main_data_in = in_data;
    main_dst_in  = in_dst;
    if (main_from_skid) begin
      main_ctrl_in = skid_ctrl;
      main_data_in = skid_data;
      main_dst_in  = skid_dst;
    end
  end

  // Occupancy state and registered in_ready.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_EMPTY;
      in_ready_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      in_ready_q <= in_ready_d;
    end
  end

  pipe_stage_slot #(
    .CTRL_W (CTRL_W),
    .DATA_W (DATA_W),
    .DST_W  (DST_W)
  ) u_main (
    .clk    (clk),
    .reset  (reset),
    .load   (load_main),
    .d_ctrl (main_ctrl_in),
    .d_data (main_data_in),
    .d_dst  (main_dst_in),
    .q_ctrl (main_ctrl),
    .q_data (main_data),
    .q_dst  (main_dst)
  );

  pipe_stage_slot #(
    .CTRL_W (CTRL_W),
    .DATA_W (DATA_W),
    .DST_W  (DST_W)
  ) u_skid (
    .clk    (clk),
    .reset  (reset),
    .load   (load_skid),
    .d_ctrl (in_ctrl),
    .d_data (in_data),
    .d_dst  (in_dst),
    .q_ctrl (skid_ctrl),
    .q_data (skid_data),
    .q_dst  (skid_dst)
  );

  assign in_ready = in_ready_q;
  assign out_ctrl = out_valid ? main_ctrl : '0;
  assign out_data = main_data;
  assign out_dst  = main_dst;

`ifdef PIPE_STAGE_STATS_EN
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  // Count cycles where a valid entry is held back; saturate at all-ones.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (out_valid && !out_ready && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + 1'b1;
    end
  end

  // Stall counter, cleared only by reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench for pipe_stage_reg. Inputs change and outputs are
// sampled on the falling clock edge.
module tb_pipe_stage_reg;

  localparam int unsigned CTRL_W = 2;
  localparam int unsigned DATA_W = 64;
  localparam int unsigned DST_W  = 5;
  localparam int unsigned CNT_W  = 4;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              flush = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [CTRL_W-1:0] in_ctrl = '0;
  logic [DATA_W-1:0] in_data = '0;
  logic [DST_W-1:0]  in_dst = '0;
  logic              out_valid;
  logic              out_ready = 1'b1;
  logic [CTRL_W-1:0] out_ctrl;
  logic [DATA_W-1:0] out_data;
  logic [DST_W-1:0]  out_dst;
`ifdef PIPE_STAGE_STATS_EN
  logic [CNT_W-1:0]  stall_cnt;
`endif

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  pipe_stage_reg #(
    .CTRL_W (CTRL_W),
    .DATA_W (DATA_W),
    .DST_W  (DST_W),
    .CNT_W  (CNT_W)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_ctrl   (in_ctrl),
    .in_data   (in_data),
    .in_dst    (in_dst),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_ctrl  (out_ctrl),
    .out_data  (out_data),
    .out_dst   (out_dst)
`ifdef PIPE_STAGE_STATS_EN
    ,
    .stall_cnt (stall_cnt)
`endif
  );

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end else begin
      $display("ok   %s: %0h", tag, got);
    end
  endtask

  task automatic drive(input logic v, input logic [1:0] c, input logic [63:0] d, input logic [4:0] r);
    in_valid = v;
    in_ctrl  = c;
    in_data  = d;
    in_dst   = r;
  endtask

  // Check the full visible output of a valid entry.
  task automatic check_out(input string tag, input logic [1:0] c, input logic [63:0] d, input logic [4:0] r);
    check_val({tag, ".valid"}, 64'(out_valid), 64'd1);
    check_val({tag, ".ctrl"},  64'(out_ctrl),  64'(c));
    check_val({tag, ".data"},  out_data,       d);
    check_val({tag, ".dst"},   64'(out_dst),   64'(r));
  endtask

  initial begin
    // Reset held, then released with nothing offered.
    repeat (3) @(negedge clk);
    check_val("rst.valid", 64'(out_valid), 64'd0);
    check_val("rst.ctrl",  64'(out_ctrl),  64'd0);
    check_val("rst.data",  out_data,       64'd0);
    check_val("rst.dst",   64'(out_dst),   64'd0);
    check_val("rst.ready", 64'(in_ready),  64'd1);
    reset = 1'b1;
    @(negedge clk);
    check_val("idle.valid", 64'(out_valid), 64'd0);
    check_val("idle.ctrl",  64'(out_ctrl),  64'd0);
    check_val("idle.ready", 64'(in_ready),  64'd1);
`ifdef PIPE_STAGE_STATS_EN
    check_val("rst.stall_cnt", 64'(stall_cnt), 64'd0);
`endif

    // Streaming: entries 1..8 back to back, each visible one cycle later.
    out_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      if (i > 1) begin
        check_out($sformatf("stream%0d", i - 1), 2'(i - 1), 64'(i - 1), 5'(i - 1));
        check_val($sformatf("stream%0d.ready", i - 1), 64'(in_ready), 64'd1);
      end
      drive(1'b1, 2'(i), 64'(i), 5'(i));
      @(negedge clk);
    end
    check_out("stream8", 2'd0, 64'd8, 5'd8);
    drive(1'b0, 2'd0, 64'd0, 5'd0);
    @(negedge clk);
    check_val("stream.drain.valid", 64'(out_valid), 64'd0);
    check_val("stream.drain.ctrl",  64'(out_ctrl),  64'd0);

    // Backpressure: A held, B to skid, C held upstream, then A, B, C in order.
    out_ready = 1'b0;
    drive(1'b1, 2'd3, 64'hA, 5'd10);
    @(negedge clk);
    check_out("bp.A", 2'd3, 64'hA, 5'd10);
    check_val("bp.A.ready", 64'(in_ready), 64'd1);
    drive(1'b1, 2'd2, 64'hB, 5'd11);
    @(negedge clk);
    check_out("bp.A_hold", 2'd3, 64'hA, 5'd10);
    check_val("bp.two.ready", 64'(in_ready), 64'd0);
    drive(1'b1, 2'd1, 64'hC, 5'd12);
    @(negedge clk);
    check_out("bp.A_hold2", 2'd3, 64'hA, 5'd10);
    check_val("bp.two.ready2", 64'(in_ready), 64'd0);
    out_ready = 1'b1;
    @(negedge clk);
    check_out("bp.B", 2'd2, 64'hB, 5'd11);
    check_val("bp.B.ready", 64'(in_ready), 64'd1);
    @(negedge clk);
    check_out("bp.C", 2'd1, 64'hC, 5'd12);
    drive(1'b0, 2'd0, 64'd0, 5'd0);
    @(negedge clk);
    check_val("bp.empty.valid", 64'(out_valid), 64'd0);
    check_val("bp.empty.ctrl",  64'(out_ctrl),  64'd0);

    // Flush while TWO with an entry offered.
    out_ready = 1'b0;
    drive(1'b1, 2'd3, 64'hD, 5'd13);
    @(negedge clk);
    drive(1'b1, 2'd3, 64'hE, 5'd14);
    @(negedge clk);
    check_val("fl.two.ready", 64'(in_ready), 64'd0);
    drive(1'b1, 2'd3, 64'hF, 5'd15);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    drive(1'b0, 2'd0, 64'd0, 5'd0);
    check_val("fl.valid", 64'(out_valid), 64'd0);
    check_val("fl.ctrl",  64'(out_ctrl),  64'd0);
    check_val("fl.ready", 64'(in_ready),  64'd1);
    out_ready = 1'b1;
    repeat (2) @(negedge clk);
    check_val("fl.no_leak.valid", 64'(out_valid), 64'd0);

    // Flush in ONE discards the entry accepted in the flush cycle.
    out_ready = 1'b0;
    drive(1'b1, 2'd1, 64'h11, 5'd17);
    @(negedge clk);
    drive(1'b1, 2'd2, 64'h12, 5'd18);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    drive(1'b0, 2'd0, 64'd0, 5'd0);
    check_val("fl1.valid", 64'(out_valid), 64'd0);
    check_val("fl1.ready", 64'(in_ready),  64'd1);
    out_ready = 1'b1;
    @(negedge clk);
    check_val("fl1.no_leak.valid", 64'(out_valid), 64'd0);

    // Flush together with out_fire: stage ends empty.
    drive(1'b1, 2'd3, 64'h21, 5'd19);
    @(negedge clk);
    check_out("flo.entry", 2'd3, 64'h21, 5'd19);
    drive(1'b0, 2'd0, 64'd0, 5'd0);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check_val("flo.valid", 64'(out_valid), 64'd0);

    // Async reset while TWO: outputs return to reset values before any edge.
    out_ready = 1'b0;
    drive(1'b1, 2'd3, 64'h31, 5'd20);
    @(negedge clk);
    drive(1'b1, 2'd2, 64'h32, 5'd21);
    @(negedge clk);
    drive(1'b0, 2'd0, 64'd0, 5'd0);
    check_val("ar.two.ready", 64'(in_ready), 64'd0);
    check_val("ar.two.data",  out_data,      64'h31);
    #2 reset = 1'b0;
    #1;
    check_val("ar.valid", 64'(out_valid), 64'd0);
    check_val("ar.ctrl",  64'(out_ctrl),  64'd0);
    check_val("ar.data",  out_data,       64'd0);
    check_val("ar.dst",   64'(out_dst),   64'd0);
    check_val("ar.ready", 64'(in_ready),  64'd1);
    @(negedge clk);
    reset = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    check_val("ar.after.valid", 64'(out_valid), 64'd0);

`ifdef PIPE_STAGE_STATS_EN
    // Stall counter saturates at 15 with a 4-bit width.
    check_val("st.start", 64'(stall_cnt), 64'd0);
    out_ready = 1'b0;
    drive(1'b1, 2'd1, 64'h41, 5'd22);
    @(negedge clk);
    drive(1'b0, 2'd0, 64'd0, 5'd0);
    check_val("st.zero", 64'(stall_cnt), 64'd0);
    repeat (5) @(negedge clk);
    check_val("st.five", 64'(stall_cnt), 64'd5);
    repeat (15) @(negedge clk);
    check_val("st.sat", 64'(stall_cnt), 64'd15);
    out_ready = 1'b1;
    repeat (2) @(negedge clk);
    check_val("st.hold", 64'(stall_cnt), 64'd15);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
